trivium_key_loader: RTL and testbench

- Consumer (read side) of the byte FIFO's read/read_stb handshake.
- Drains KEY_BYTES key bytes, then IV_BYTES IV bytes, one byte at a time.
- Assembles them into the Trivium 80-bit key and 80-bit IV registers, then pulses load so the cipher core can begin initialisation.
- Sits between the host-side byte FIFO and the Trivium core.

---
 rtl/trivium_key_loader.sv | 107 ++++++++++
 tb/tb_trivium_key_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_key_loader.sv
// Byte-wise loader that drains key then IV bytes from a byte FIFO and
// presents them, MSB-first, as the Trivium key/IV with a one-cycle load pulse.
module trivium_key_loader #(
   parameter int KEY_BYTES = 10,
   parameter int IV_BYTES  = 10,
   parameter int TIMEOUT   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               fifo_dout,
   input  logic [1:0]               fifo_condition,
   input  logic                     fifo_read_stb,
   output logic                     fifo_read,
   output logic [8*KEY_BYTES-1:0]   key,
   output logic [8*IV_BYTES-1:0]    iv,
   output logic                     load,
   output logic                     busy,
   output logic                     error
);

   localparam int TOTAL = KEY_BYTES + IV_BYTES;
   localparam int ASM_W = 8 * TOTAL;
   localparam int IDX_W = $clog2(TOTAL + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_REQ,
      S_WAIT,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [ASM_W-1:0]   r_asm;
   logic [IDX_W-1:0]   r_idx;
   logic [TO_W-1:0]    r_to;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_asm     <= '0;
         r_idx     <= '0;
         r_to      <= '0;
         fifo_read <= 1'b0;
         key       <= '0;
         iv        <= '0;
         load      <= 1'b0;
         busy      <= 1'b0;
         error     <= 1'b0;
      end else begin
         load <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  error   <= 1'b0;
                  r_idx   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_ARM;
               end
            end
            // An empty FIFO parks the loader here with no timeout; the
            // partial assembly and byte index are kept.
            S_ARM: begin
               if (fifo_condition != 2'b00) begin
                  fifo_read <= 1'b1;
                  r_state   <= S_REQ;
               end
            end
            S_REQ: begin
               fifo_read <= 1'b0;
               r_to      <= '0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (fifo_read_stb) begin
                  r_asm   <= {r_asm[ASM_W-9:0], fifo_dout};
                  r_idx   <= r_idx + IDX_W'(1);
                  r_state <= S_SETTLE;
               end else if (r_to == TO_W'(TIMEOUT - 1)) begin
                  error   <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_to <= r_to + TO_W'(1);
               end
            end
            // Dead cycle: the FIFO status lags its strobe, so the next
            // request must not be issued until the condition has caught up.
            S_SETTLE: begin
               r_state <= (r_idx == IDX_W'(TOTAL)) ? S_DONE : S_ARM;
            end
            S_DONE: begin
               key     <= r_asm[ASM_W-1 -: 8*KEY_BYTES];
               iv      <= r_asm[8*IV_BYTES-1:0];
               load    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trivium_key_loader.sv
// Directed/randomized bench for trivium_key_loader with a behavioural FIFO
// and a byte-stream reference model for the expected key/IV.
module tb_trivium_key_loader;

   localparam int KB    = 10;
   localparam int IB    = 10;
   localparam int TO    = 4;
   localparam int TOT   = KB + IB;
   localparam int DEPTH = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    fifo_dout;
   logic [1:0]    fifo_condition;
   logic          fifo_read_stb;
   logic          fifo_read;
   logic [79:0]   key;
   logic [79:0]   iv;
   logic          load;
   logic          busy;
   logic          error;

   always #5 clk = ~clk;

   trivium_key_loader #(.KEY_BYTES(KB), .IV_BYTES(IB), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .fifo_dout      (fifo_dout),
      .fifo_condition (fifo_condition),
      .fifo_read_stb  (fifo_read_stb),
      .fifo_read      (fifo_read),
      .key            (key),
      .iv             (iv),
      .load           (load),
      .busy           (busy),
      .error          (error)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  q[$];
   logic [7:0]  stream [TOT];
   logic [79:0] exp_key, exp_iv, prev_key, prev_iv;
   bit          pending, pend_sup, spur;
   int          sup_k, sup_rd_n;
   int          n, rd_cnt, load_cnt, load_n, first_rd_n, last_rd_n, gap_bad, dbl_rd, err_n;
   bit          prev_rd, cur_busy, busy_before_load;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic upd_cond();
      fifo_condition = (q.size() == 0) ? 2'b00 : (q.size() >= DEPTH) ? 2'b11 : 2'b10;
   endtask

   // Reference: byte i of the stream is the i-th most significant byte of key||iv.
   task automatic model();
      exp_key = '0;
      exp_iv  = '0;
      for (int i = 0; i < TOT; i++) begin
         if (i < KB) exp_key[8*(KB-1-i) +: 8] = stream[i];
         else        exp_iv[8*(IB-1-(i-KB)) +: 8] = stream[i];
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < TOT; i++) stream[i] = 8'($urandom);
   endtask

   task automatic push_range(input int a, input int b);
      for (int i = a; i < b; i++) q.push_back(stream[i]);
      upd_cond();
   endtask

   task automatic flush_fifo();
      q.delete();
      pending = 1'b0;
      pend_sup = 1'b0;
      fifo_read_stb = 1'b0;
      upd_cond();
   endtask

   task automatic reset_counters();
      n = 0; rd_cnt = 0; load_cnt = 0; load_n = -1; first_rd_n = -1; last_rd_n = -1;
      gap_bad = 0; dbl_rd = 0; err_n = -1; prev_rd = 1'b0; sup_rd_n = -1;
   endtask

   // One clock: observe outputs just after the edge, then play the FIFO for the next edge.
   task automatic step();
      @(posedge clk); #1;
      n++;
      if (fifo_read) begin
         rd_cnt++;
         if (prev_rd) dbl_rd++;
         if (first_rd_n < 0) first_rd_n = n;
         if (last_rd_n >= 0 && (n - last_rd_n) != 4) gap_bad++;
         last_rd_n = n;
      end
      prev_rd = fifo_read;
      if (load) begin
         load_cnt++;
         if (load_n < 0) begin
            load_n = n;
            busy_before_load = cur_busy;
         end
      end
      cur_busy = busy;
      if (error && err_n < 0) err_n = n;
      if (spur) begin
         fifo_read_stb = 1'b1;
         fifo_dout     = 8'hFF;
         spur          = 1'b0;
      end else if (pending) begin
         pending = 1'b0;
         if (pend_sup || q.size() == 0) begin
            fifo_read_stb = 1'b0;
            fifo_dout     = 8'($urandom);
         end else begin
            fifo_read_stb = 1'b1;
            fifo_dout     = q.pop_front();
         end
      end else begin
         fifo_read_stb = 1'b0;
         fifo_dout     = 8'($urandom);
      end
      if (fifo_read) begin
         pending  = 1'b1;
         pend_sup = (rd_cnt == sup_k);
         if (pend_sup) sup_rd_n = n;
      end
      upd_cond();
   endtask

   task automatic pulse_start();
      reset_counters();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_to_load(input int budget);
      while (load_cnt == 0 && n < budget) step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; fifo_dout = 8'h00; fifo_read_stb = 1'b0;
      fifo_condition = 2'b00; pending = 1'b0; pend_sup = 1'b0; spur = 1'b0;
      sup_k = -1; cur_busy = 1'b0; busy_before_load = 1'b0;
      reset_counters();
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 80'({fifo_read, load, busy, error}), 80'h0);
      check("reset_key", key, 80'h0);
      check("reset_iv", iv, 80'h0);
      rst = 1'b0;

      // Contiguous load of 0x01..0x14 (FIFO starts full: condition 11)
      for (int i = 0; i < TOT; i++) stream[i] = 8'(i + 1);
      push_range(0, TOT);
      check("cond_full", 80'(fifo_condition), 80'h3);
      pulse_start();
      run_to_load(200);
      check("t1_load_cycle", 80'(load_n), 80'd82);
      check("t1_rd_cnt", 80'(rd_cnt), 80'd20);
      check("t1_first_rd", 80'(first_rd_n), 80'd2);
      check("t1_rd_gap", 80'(gap_bad), 80'd0);
      check("t1_rd_single", 80'(dbl_rd), 80'd0);
      check("t1_key", key, 80'h0102030405060708090A);
      check("t1_iv", iv, 80'h0B0C0D0E0F1011121314);
      check("t1_busy_done", 80'(busy_before_load), 80'd1);
      step();
      check("t1_load_single", 80'(load), 80'd0);
      check("t1_busy_fall", 80'(busy), 80'd0);
      check("t1_error", 80'(error), 80'd0);

      // Underflow: 5 bytes, park, remaining 15 arrive 30 cycles later
      fill_random(); model();
      push_range(0, 5);
      pulse_start();
      while (n < 51) step();
      check("t2_park_rd_cnt", 80'(rd_cnt), 80'd5);
      check("t2_park_rd_low", 80'(fifo_read), 80'd0);
      check("t2_park_busy", 80'(busy), 80'd1);
      push_range(5, TOT);
      run_to_load(400);
      check("t2_load_cnt", 80'(load_cnt), 80'd1);
      check("t2_rd_cnt", 80'(rd_cnt), 80'd20);
      check("t2_key", key, exp_key);
      check("t2_iv", iv, exp_iv);
      prev_key = exp_key; prev_iv = exp_iv;

      // Strobe suppressed for the 3rd request -> timeout
      fill_random();
      push_range(0, TOT);
      sup_k = 3;
      pulse_start();
      while (err_n < 0 && n < 100) step();
      check("t3_err_time", 80'(err_n - sup_rd_n), 80'(TO + 1));
      repeat (5) step();
      sup_k = -1;
      check("t3_no_load", 80'(load_cnt), 80'd0);
      check("t3_rd_cnt", 80'(rd_cnt), 80'd3);
      check("t3_key_hold", key, prev_key);
      check("t3_iv_hold", iv, prev_iv);
      check("t3_idle", 80'({busy, error}), 80'b01);
      flush_fifo();
      fill_random(); model();
      push_range(0, TOT);
      pulse_start();
      check("t3_err_clear", 80'({busy, error}), 80'b10);
      run_to_load(200);
      check("t3_key", key, exp_key);
      check("t3_iv", iv, exp_iv);

      // Start pulsed mid-sequence is ignored
      fill_random(); model();
      push_range(0, TOT);
      pulse_start();
      while (n < 30) step();
      start = 1'b1;
      step();
      start = 1'b0;
      run_to_load(200);
      repeat (8) step();
      check("t4_rd_cnt", 80'(rd_cnt), 80'd20);
      check("t4_load_cnt", 80'(load_cnt), 80'd1);
      check("t4_busy", 80'(busy), 80'd0);
      check("t4_key", key, exp_key);
      check("t4_iv", iv, exp_iv);

      // Asynchronous reset after the 7th byte
      fill_random();
      push_range(0, TOT);
      pulse_start();
      while (rd_cnt < 7 && n < 200) step();
      step(); step();
      #2 rst = 1'b1;
      #1;
      check("t5_rst_ctrl", 80'({fifo_read, load, busy, error}), 80'h0);
      check("t5_rst_key", key, 80'h0);
      check("t5_rst_iv", iv, 80'h0);
      @(negedge clk);
      rst = 1'b0;
      flush_fifo();
      fill_random(); model();
      push_range(0, TOT);
      pulse_start();
      run_to_load(200);
      check("t5_load_cycle", 80'(load_n), 80'd82);
      check("t5_key", key, exp_key);
      check("t5_iv", iv, exp_iv);

      // Spurious strobe with 0xFF while parked in ARM
      fill_random(); model();
      push_range(0, 3);
      pulse_start();
      while (n < 25) step();
      spur = 1'b1;
      while (n < 35) step();
      check("t6_park_rd_cnt", 80'(rd_cnt), 80'd3);
      push_range(3, TOT);
      run_to_load(300);
      check("t6_load_cnt", 80'(load_cnt), 80'd1);
      check("t6_key", key, exp_key);
      check("t6_iv", iv, exp_iv);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
